dso_cfg_regs: RTL
=================

DSO_CFG_REGS -- requirements
Module: dso_cfg_regs

Interface
REQ-001 SHALL have parameter CH_NUM, default 2, meaning the number of trigger channels (legal 1..4).
REQ-002 SHALL have parameter DIV_W, default 24, meaning the sample-divider and trigger-position width (legal 8/16/24).
REQ-003 SHALL have parameter VAL_W, default 16, meaning the per-channel trigger-value width (legal 8/16).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning the command FIFO depth (power of 2, 4..64).
REQ-005 Ports SHALL be:
- core_clk  in  1  sole clock, rising edge.
- core_rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  byte-write strobe.
- addr  in  8  register address: [7:2] block, [1:0] byte lane.
- wdata  in  8  write data.
- rdata  out  8  readback of the staged byte at addr.
- cmd_data  out  8  FIFO head byte.
- cmd_valid  out  1  FIFO not empty.
- cmd_ready  in  1  consumer accepts the head byte.
- cmd_overflow  out  1  sticky flag: a write was dropped because the FIFO was full.
- dso_sampleDivider  out  DIV_W  active divider.
- dso_triggerPos  out  DIV_W  active trigger position.
- dso_triggerValue  out  CH_NUM*VAL_W  active values, channel c at [c*VAL_W +: VAL_W].
- dso_triggerSlope  out  CH_NUM*8  active slopes.
- dso_triggerSource  out  CH_NUM*8  active sources.
- dso_setZero  out  1  one-cycle pulse.
- cfg_update  out  1  one-cycle pulse, high on any active-register change.

Function
REQ-006 Block map SHALL be:
- 0: command FIFO push (any lane).
- 1: sampleDivider.
- 2: triggerPos.
- 3: control.
- 4+2c: channel c triggerValue.
- 5+2c: channel c slope (lane 0) and source (lane 1).
REQ-007 Writes to unmapped blocks, lanes beyond a register's byte width, or channels >= CH_NUM SHALL be ignored and SHALL read back 0x00.
REQ-008 Each multi-byte register SHALL have a staged copy written per lane and an active copy driving the outputs.
REQ-009 Commit lane SHALL be the highest lane of the register (DIV_W/8-1; VAL_W/8-1; lane 1 for block 5+2c); writing it SHALL copy the whole staged register, including that byte, to active.
REQ-010 Committed values SHALL appear on the outputs on the clock edge after the commit write, with cfg_update high for exactly that cycle.
REQ-011 Control lane 0 bit0 (hold) SHALL be read/write. While hold=1, commits SHALL set a per-register pending bit instead of updating the active copy.
REQ-012 Writing hold 1->0 SHALL copy every pending register to active in one cycle, clear all pending bits and pulse cfg_update once; if nothing is pending, there SHALL be no pulse.
REQ-013 Control lane 1 bit0 written as 1 SHALL clear cmd_overflow (write-1-to-clear); other bits SHALL be ignored.
REQ-014 Control lane 2, any write, SHALL pulse dso_setZero on the following cycle, independent of hold.
REQ-015 rdata SHALL be combinational from addr and SHALL return the staged byte. Block 0 SHALL return {cmd_overflow, 1'b0, fill count[5:0]}; control lane 0 SHALL return {7'b0, hold}.
REQ-016 The FIFO SHALL pop when cmd_valid and cmd_ready are both high. cmd_data SHALL be valid whenever cmd_valid is high (first-word-fall-through).
REQ-017 A push to a full FIFO without a same-cycle pop SHALL drop the byte and set cmd_overflow; a push and pop in the same cycle while full SHALL both succeed.
REQ-018 Pointers SHALL wrap modulo FIFO_DEPTH. Full and empty SHALL be distinguished by a one-bit-extended pointer.

Reset
REQ-019 On core_rst, staged and active registers, pending bits, hold, cmd_overflow, dso_setZero and cfg_update SHALL be 0, and the FIFO SHALL be empty (cmd_valid=0).
REQ-020 Reset asserted mid-transfer SHALL discard any partially staged bytes; after release no commit SHALL occur without a new commit-lane write.

Structure
REQ-021 A shared package SHALL hold the block-number constants, the control bit positions and the legal-parameter checks.
REQ-022 The FIFO SHALL be one sub-module, dso_cmd_fifo, parametrised by depth, exposing fill count, full and empty.

Verification
REQ-023 Write divider lanes 0x10, 0x20, 0x03 -> dso_sampleDivider=0x032010 one edge after the lane-2 write, cfg_update pulses once, and there is no change after lanes 0/1 alone.
REQ-024 hold=1; commit ch1 value 0xBEEF and triggerPos 0x000100; hold=0 -> both outputs change on the same edge, one cfg_update pulse, and neither changes before release.
REQ-025 Push 17 bytes to a 16-deep FIFO with cmd_ready=0 -> 16 stored, cmd_overflow=1 and block-0 readback 0x90; W1C clears the flag; draining returns bytes in order.
REQ-026 FIFO full with a push and cmd_ready=1 in the same cycle -> fill stays 16 and cmd_overflow stays 0.
REQ-027 CH_NUM=2, write block 8 (channel 2) -> no output change and readback 0x00; control lane-2 write -> single dso_setZero pulse.
REQ-028 Assert core_rst after lane-0 divider write, then write lane 2 = 0x01 -> dso_sampleDivider=0x010000.

Source files
------------

// File: rtl/dso_cfg_regs_pkg.sv
// Shared constants for the DSO configuration register block: block map,
// control-register lane/bit positions and parameter legality checks.
package dso_cfg_regs_pkg;

  localparam logic [5:0] BLK_FIFO    = 6'd0;
  localparam logic [5:0] BLK_DIV     = 6'd1;
  localparam logic [5:0] BLK_POS     = 6'd2;
  localparam logic [5:0] BLK_CTRL    = 6'd3;
  localparam logic [5:0] BLK_CH_BASE = 6'd4;

  localparam logic [1:0] CTRL_LANE_HOLD    = 2'd0;
  localparam logic [1:0] CTRL_LANE_OVF_CLR = 2'd1;
  localparam logic [1:0] CTRL_LANE_ZERO    = 2'd2;
  localparam int         CTRL_HOLD_BIT     = 0;
  localparam int         CTRL_OVF_CLR_BIT  = 0;

  // Channel c owns two consecutive blocks: trigger value, then slope/source.
  function automatic logic [5:0] ch_val_blk(input int c);
    return 6'(int'(BLK_CH_BASE) + 2 * c);
  endfunction

  function automatic logic [5:0] ch_cfg_blk(input int c);
    return 6'(int'(BLK_CH_BASE) + 2 * c + 1);
  endfunction

  function automatic bit legal_ch_num(input int n);
    return (n >= 1) && (n <= 4);
  endfunction

  function automatic bit legal_div_w(input int w);
    return (w == 8) || (w == 16) || (w == 24);
  endfunction

  function automatic bit legal_val_w(input int w);
    return (w == 8) || (w == 16);
  endfunction

  function automatic bit legal_fifo_depth(input int d);
    return (d >= 4) && (d <= 64) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/dso_cmd_fifo.sv
// Byte-wide first-word-fall-through command FIFO. Pointers carry one extra
// wrap bit so that full and empty are distinguishable.
module dso_cmd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; wrap is implicit in the AW+1 bit arithmetic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care while empty so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/dso_cfg_regs.sv
// DSO configuration registers: byte-addressed staged/active register pairs,
// hold-and-release commit, set-zero pulse and a command byte FIFO.
module dso_cfg_regs
  import dso_cfg_regs_pkg::*;
#(
  parameter int CH_NUM     = 2,
  parameter int DIV_W      = 24,
  parameter int VAL_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic                  wr_en,
  input  logic [7:0]            addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [7:0]            cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_overflow,
  output logic [DIV_W-1:0]      dso_sampleDivider,
  output logic [DIV_W-1:0]      dso_triggerPos,
  output logic [CH_NUM*VAL_W-1:0] dso_triggerValue,
  output logic [CH_NUM*8-1:0]   dso_triggerSlope,
  output logic [CH_NUM*8-1:0]   dso_triggerSource,
  output logic                  dso_setZero,
  output logic                  cfg_update
);
  localparam int DIV_B = DIV_W / 8;
  localparam int VAL_B = VAL_W / 8;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  if (!(legal_ch_num(CH_NUM) && legal_div_w(DIV_W) && legal_val_w(VAL_W) &&
        legal_fifo_depth(FIFO_DEPTH))) begin : g_bad_param
    $error("dso_cfg_regs: illegal parameter combination");
  end

  logic [5:0]       blk;
  logic [1:0]       lane;
  logic             ctrl_wr;
  logic             release_hold;
  logic             any_pend;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic [DIV_W-1:0] div_stg, div_nxt, div_act, pos_stg, pos_nxt, pos_act;
  logic [VAL_W-1:0] val_stg [CH_NUM];
  logic [VAL_W-1:0] val_nxt [CH_NUM];
  logic [VAL_W-1:0] val_act [CH_NUM];
  logic [7:0]       slope_stg [CH_NUM];
  logic [7:0]       slope_nxt [CH_NUM];
  logic [7:0]       slope_act [CH_NUM];
  logic [7:0]       src_stg [CH_NUM];
  logic [7:0]       src_nxt [CH_NUM];
  logic [7:0]       src_act [CH_NUM];

  logic              div_cmt, pos_cmt, div_pend, pos_pend;
  logic [CH_NUM-1:0] val_cmt, cfg_cmt, val_pend, cfg_pend;
  logic              hold;

  assign blk          = addr[7:2];
  assign lane         = addr[1:0];
  assign ctrl_wr      = wr_en && (blk == BLK_CTRL);
  assign release_hold = ctrl_wr && (lane == CTRL_LANE_HOLD) && hold && !wdata[CTRL_HOLD_BIT];
  assign any_pend     = div_pend || pos_pend || (|val_pend) || (|cfg_pend);
  assign fifo_push    = wr_en && (blk == BLK_FIFO);
  assign cmd_valid    = !fifo_empty;

  dso_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (core_clk),
    .rst   (core_rst),
    .push  (fifo_push),
    .data  (wdata),
    .pop   (cmd_ready),
    .head  (cmd_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next staged contents with the written byte merged in, plus commit-lane decode.
  always_comb begin
    div_nxt   = div_stg;
    pos_nxt   = pos_stg;
    val_nxt   = val_stg;
    slope_nxt = slope_stg;
    src_nxt   = src_stg;
    div_cmt   = 1'b0;
    pos_cmt   = 1'b0;
    val_cmt   = '0;
    cfg_cmt   = '0;
    if (wr_en) begin
      for (int b = 0; b < DIV_B; b++) begin
        if (int'(lane) == b && blk == BLK_DIV) div_nxt[b*8 +: 8] = wdata;
        if (int'(lane) == b && blk == BLK_POS) pos_nxt[b*8 +: 8] = wdata;
      end
      div_cmt = (blk == BLK_DIV) && (int'(lane) == DIV_B - 1);
      pos_cmt = (blk == BLK_POS) && (int'(lane) == DIV_B - 1);
      for (int c = 0; c < CH_NUM; c++) begin
        for (int b = 0; b < VAL_B; b++) begin
          if (int'(lane) == b && blk == ch_val_blk(c)) val_nxt[c][b*8 +: 8] = wdata;
        end
        val_cmt[c] = (blk == ch_val_blk(c)) && (int'(lane) == VAL_B - 1);
        if (blk == ch_cfg_blk(c) && lane == 2'd0) slope_nxt[c] = wdata;
        if (blk == ch_cfg_blk(c) && lane == 2'd1) src_nxt[c]   = wdata;
        cfg_cmt[c] = (blk == ch_cfg_blk(c)) && (lane == 2'd1);
      end
    end
  end

  // Staged copies track every lane write.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      div_stg <= '0;
      pos_stg <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        val_stg[c]   <= '0;
        slope_stg[c] <= '0;
        src_stg[c]   <= '0;
      end
    end else begin
      div_stg   <= div_nxt;
      pos_stg   <= pos_nxt;
      val_stg   <= val_nxt;
      slope_stg <= slope_nxt;
      src_stg   <= src_nxt;
    end
  end

  // Active copies: direct commit when not held, otherwise mark pending and flush on release.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      div_act    <= '0;
      pos_act    <= '0;
      div_pend   <= 1'b0;
      pos_pend   <= 1'b0;
      val_pend   <= '0;
      cfg_pend   <= '0;
      cfg_update <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        val_act[c]   <= '0;
        slope_act[c] <= '0;
        src_act[c]   <= '0;
      end
    end else begin
      cfg_update <= 1'b0;
      if (release_hold) begin
        if (div_pend) div_act <= div_stg;
        if (pos_pend) pos_act <= pos_stg;
        for (int c = 0; c < CH_NUM; c++) begin
          if (val_pend[c]) val_act[c] <= val_stg[c];
          if (cfg_pend[c]) begin
            slope_act[c] <= slope_stg[c];
            src_act[c]   <= src_stg[c];
          end
        end
        div_pend   <= 1'b0;
        pos_pend   <= 1'b0;
        val_pend   <= '0;
        cfg_pend   <= '0;
        cfg_update <= any_pend;
      end
      if (div_cmt) begin
        if (hold) div_pend <= 1'b1;
        else begin div_act <= div_nxt; cfg_update <= 1'b1; end
      end
      if (pos_cmt) begin
        if (hold) pos_pend <= 1'b1;
        else begin pos_act <= pos_nxt; cfg_update <= 1'b1; end
      end
      for (int c = 0; c < CH_NUM; c++) begin
        if (val_cmt[c]) begin
          if (hold) val_pend[c] <= 1'b1;
          else begin val_act[c] <= val_nxt[c]; cfg_update <= 1'b1; end
        end
        if (cfg_cmt[c]) begin
          if (hold) cfg_pend[c] <= 1'b1;
          else begin
            slope_act[c] <= slope_nxt[c];
            src_act[c]   <= src_nxt[c];
            cfg_update   <= 1'b1;
          end
        end
      end
    end
  end

  // Control register: hold bit, sticky overflow with write-1-to-clear, set-zero pulse.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      hold         <= 1'b0;
      cmd_overflow <= 1'b0;
      dso_setZero  <= 1'b0;
    end else begin
      if (ctrl_wr && lane == CTRL_LANE_HOLD) hold <= wdata[CTRL_HOLD_BIT];
      if (fifo_push && fifo_full && !cmd_ready) cmd_overflow <= 1'b1;
      else if (ctrl_wr && lane == CTRL_LANE_OVF_CLR && wdata[CTRL_OVF_CLR_BIT])
        cmd_overflow <= 1'b0;
      dso_setZero <= ctrl_wr && (lane == CTRL_LANE_ZERO);
    end
  end

  // Active copies packed onto the output buses.
  always_comb begin
    dso_sampleDivider = div_act;
    dso_triggerPos    = pos_act;
    dso_triggerValue  = '0;
    dso_triggerSlope  = '0;
    dso_triggerSource = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      dso_triggerValue[c*VAL_W +: VAL_W] = val_act[c];
      dso_triggerSlope[c*8 +: 8]         = slope_act[c];
      dso_triggerSource[c*8 +: 8]        = src_act[c];
    end
  end

  // Readback of the staged byte at addr; unmapped locations read as zero.
  always_comb begin
    rdata = 8'h00;
    if (blk == BLK_FIFO) rdata = {cmd_overflow, 1'b0, 6'(fifo_count)};
    if (blk == BLK_CTRL && lane == CTRL_LANE_HOLD) rdata = {7'b0, hold};
    for (int b = 0; b < DIV_B; b++) begin
      if (int'(lane) == b && blk == BLK_DIV) rdata = div_stg[b*8 +: 8];
      if (int'(lane) == b && blk == BLK_POS) rdata = pos_stg[b*8 +: 8];
    end
    for (int c = 0; c < CH_NUM; c++) begin
      for (int b = 0; b < VAL_B; b++) begin
        if (int'(lane) == b && blk == ch_val_blk(c)) rdata = val_stg[c][b*8 +: 8];
      end
      if (blk == ch_cfg_blk(c) && lane == 2'd0) rdata = slope_stg[c];
      if (blk == ch_cfg_blk(c) && lane == 2'd1) rdata = src_stg[c];
    end
  end

endmodule
